// File: rtl/ex_stage_unit.sv
// Execute stage: ALU, branch resolution, destination select, iterative MUL (and DIV/REM).
// Optional divider is built only when EX_DIV_EN is defined; otherwise DIV/REM retire as no-write ops.
module ex_stage_unit #(
   parameter int MULDIV_ITERS = 32,
   parameter int PC_W         = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            inFlush,
   input  logic [PC_W-1:0] inPc,
   input  logic [31:0]     inReadData1,
   input  logic [31:0]     inReadData2,
   input  logic [31:0]     inSignExtImm,
   input  logic [4:0]      inRb,
   input  logic [4:0]      inRd,
   input  logic            inRegDst,
   input  logic            inALUSrc,
   input  logic            inMemToReg,
   input  logic            inRegWrite,
   input  logic            inMemRead,
   input  logic            inMemWrite,
   input  logic            inBranch,
   input  logic [4:0]      inALUOp,
   output logic [31:0]     outAluResult,
   output logic [31:0]     outWriteData,
   output logic [4:0]      outDestReg,
   output logic            outMemToReg,
   output logic            outRegWrite,
   output logic            outMemRead,
   output logic            outMemWrite,
   output logic            outBranchTaken,
   output logic [PC_W-1:0] outBranchTarget,
   output logic            outStall
);
   localparam int CNT_W = (MULDIV_ITERS > 1) ? $clog2(MULDIV_ITERS) : 1;
   localparam logic [4:0] OP_ADD = 5'd0, OP_SUB = 5'd1, OP_AND = 5'd2, OP_OR = 5'd3,
                          OP_XOR = 5'd4, OP_SLL = 5'd5, OP_SRL = 5'd6, OP_SRA = 5'd7,
                          OP_SLT = 5'd8, OP_PASSB = 5'd9, OP_MUL = 5'd10, OP_DIV = 5'd11,
                          OP_REM = 5'd12, OP_NOP = 5'd31;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   typedef struct packed {
      logic [31:0]     res;
      logic [31:0]     wdata;
      logic [4:0]      dest;
      logic            memtoreg, regwrite, memread, memwrite, brtaken;
      logic [PC_W-1:0] brtgt;
   } ex_out_t;

   state_t           state_q, state_d;
   ex_out_t          out_q, out_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]      acc_q, acc_d, opa_q, opa_d, opb_q, opb_d;
   logic [31:0]      opB, alu_res, unit_res;
   logic             multi, is_divrem, nop;

   assign opB       = inALUSrc ? inSignExtImm : inReadData2;
   assign is_divrem = (inALUOp == OP_DIV) || (inALUOp == OP_REM);
   assign nop       = (inALUOp == OP_NOP);
`ifdef EX_DIV_EN
   logic [4:0]  op_q, op_d;
   logic [32:0] shifted;
   assign multi    = (inALUOp == OP_MUL) || is_divrem;
   assign unit_res = (op_q == OP_DIV) ? opa_q : acc_q;
`else
   assign multi    = (inALUOp == OP_MUL);
   assign unit_res = acc_q;
`endif

   always_comb begin
      alu_res = '0;
      case (inALUOp)
         OP_ADD:   alu_res = inReadData1 + opB;
         OP_SUB:   alu_res = inReadData1 - opB;
         OP_AND:   alu_res = inReadData1 & opB;
         OP_OR:    alu_res = inReadData1 | opB;
         OP_XOR:   alu_res = inReadData1 ^ opB;
         OP_SLL:   alu_res = inReadData1 << opB[4:0];
         OP_SRL:   alu_res = inReadData1 >> opB[4:0];
         OP_SRA:   alu_res = $signed(inReadData1) >>> opB[4:0];
         OP_SLT:   alu_res = {31'd0, $signed(inReadData1) < $signed(opB)};
         OP_PASSB: alu_res = opB;
         default:  alu_res = '0;
      endcase
   end

   // Shared iterative datapath: MUL uses acc/opa/opb as product/multiplicand/multiplier,
   // DIV/REM reuse them as remainder/quotient-dividend/divisor.
   always_comb begin
      acc_d = acc_q;
      opa_d = opa_q;
      opb_d = opb_q;
      cnt_d = cnt_q;
`ifdef EX_DIV_EN
      op_d    = op_q;
      shifted = {acc_q, opa_q[31]};
`endif
      if (state_q == IDLE && multi) begin
         acc_d = '0;
         opa_d = inReadData1;
         opb_d = opB;
         cnt_d = '0;
`ifdef EX_DIV_EN
         op_d  = inALUOp;
`endif
      end else if (state_q == BUSY) begin
         cnt_d = cnt_q + CNT_W'(1);
`ifdef EX_DIV_EN
         if (op_q != OP_MUL) begin
            if (shifted >= {1'b0, opb_q}) begin
               acc_d = shifted[31:0] - opb_q;
               opa_d = {opa_q[30:0], 1'b1};
            end else begin
               acc_d = shifted[31:0];
               opa_d = {opa_q[30:0], 1'b0};
            end
         end else
`endif
         begin
            if (opb_q[0]) acc_d = acc_q + opa_q;
            opa_d = opa_q << 1;
            opb_d = opb_q >> 1;
         end
      end
      if (inFlush) cnt_d = '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         out_q   <= '0;
         cnt_q   <= '0;
         acc_q   <= '0;
         opa_q   <= '0;
         opb_q   <= '0;
`ifdef EX_DIV_EN
         op_q    <= '0;
`endif
      end else begin
         state_q <= state_d;
         out_q   <= out_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         opa_q   <= opa_d;
         opb_q   <= opb_d;
`ifdef EX_DIV_EN
         op_q    <= op_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (multi) state_d = BUSY;
         BUSY:    if (cnt_q == CNT_W'(MULDIV_ITERS - 1)) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (inFlush) state_d = IDLE;
   end

   always_comb begin
      outStall = !inFlush && ((state_q == IDLE && multi) || state_q == BUSY);
      out_d    = '0;
      if (!inFlush && !nop && (state_q == DONE || (state_q == IDLE && !multi))) begin
         out_d.res      = (state_q == DONE) ? unit_res : alu_res;
         out_d.wdata    = inReadData2;
         out_d.dest     = inRegDst ? inRd : inRb;
         out_d.memtoreg = inMemToReg;
`ifdef EX_DIV_EN
         out_d.regwrite = inRegWrite;
`else
         out_d.regwrite = inRegWrite && !is_divrem;
`endif
         out_d.memread  = inMemRead;
         out_d.memwrite = inMemWrite;
         out_d.brtaken  = inBranch && ((inReadData1 - opB) == 32'd0);
         out_d.brtgt    = inPc + inSignExtImm[PC_W-1:0];
      end
   end

   assign outAluResult    = out_q.res;
   assign outWriteData    = out_q.wdata;
   assign outDestReg      = out_q.dest;
   assign outMemToReg     = out_q.memtoreg;
   assign outRegWrite     = out_q.regwrite;
   assign outMemRead      = out_q.memread;
   assign outMemWrite     = out_q.memwrite;
   assign outBranchTaken  = out_q.brtaken;
   assign outBranchTarget = out_q.brtgt;
endmodule

// File: doc/ex_stage_unit.md
Name: ex_stage_unit

Overview:
Execute stage. Consumes the ID/EX pipeline register outputs and performs ALU operations, branch resolution and destination-register selection. It drives a registered EX/MEM-side bundle. Single-cycle ops complete in 1 cycle. MUL, and optionally DIV/REM, run on an iterative unit that raises outStall back to IF/ID/ID-EX until the result is written.

Parameters:
MULDIV_ITERS, 32, iteration count of the multi-cycle unit (one operand bit per cycle; must equal data width)
PC_W, 8, program-counter width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
inFlush  in  1  kill the current op and output a bubble next edge
inPc  in  PC_W  PC of the instruction in EX
inReadData1  in  32  operand A
inReadData2  in  32  register operand B / store data
inSignExtImm  in  32  immediate
inRb  in  5  base register
inRd  in  5  destination register
inRegDst, inALUSrc, inMemToReg, inRegWrite, inMemRead, inMemWrite, inBranch  in  1 each  control bits from ID/EX
inALUOp  in  5  operation code; 5'b11111 = NOP
outAluResult  out  32  registered result
outWriteData  out  32  registered inReadData2 (store data)
outDestReg  out  5  registered destination register
outMemToReg, outRegWrite, outMemRead, outMemWrite  out  1 each  registered controls
outBranchTaken  out  1  registered branch decision
outBranchTarget  out  PC_W  registered branch target
outStall  out  1  combinational: hold upstream stages

Behaviour:
- Reset (async, rst=1): every registered output = 0; FSM = IDLE; iteration counter = 0.
- OpB = inALUSrc ? inSignExtImm : inReadData2. Dest = inRegDst ? inRd : inRb.
- ALUOp codes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR.
  - 5 SLL, 6 SRL, 7 SRA; shift amount = OpB[4:0].
  - 8 SLT (signed, result 1/0), 9 PASSB.
  - 10 MUL (unsigned, low 32 bits), 11 DIV, 12 REM (unsigned).
  - 31 NOP. Any other code: result 0.
  - All arithmetic is 32-bit wrap-around, with no overflow flag.
- Branch: taken = inBranch && (inReadData1 - OpB == 0). Target = inPc + inSignExtImm[PC_W-1:0], modulo 2^PC_W.
- FSM states IDLE, BUSY, DONE:
  - IDLE with a single-cycle op: outputs latch result and controls at the next edge (latency 1). outStall = 0.
  - IDLE with a multi-cycle op (MUL/DIV/REM): outStall = 1. At the edge, capture operands, counter = 0, go to BUSY. Registered outputs take a bubble (all 0).
  - BUSY: outStall = 1. One iteration per edge, bubble outputs. When counter = MULDIV_ITERS-1, go to DONE.
  - DONE: outStall = 0. At the edge, outputs latch the unit result plus controls (still held on the inputs), then go to IDLE.
  - Total: result visible MULDIV_ITERS+2 edges after the instruction is first presented (34 by default).
- DIV by zero: quotient = 32'hFFFFFFFF, remainder = dividend. No trap.
- inFlush: highest priority after rst. At the next edge: FSM to IDLE, counter = 0, outputs = bubble. outStall drops combinationally in the flush cycle.
- NOP or bubble: all control outputs = 0, outAluResult = 0.
- Upstream must hold all inputs stable while outStall = 1. The block does not re-sample the operands during BUSY.

Optional Feature:
EX_DIV_EN
- Defined: DIV/REM use the iterative restoring divider and share the BUSY/DONE path with MUL.
- Undefined: no divider is built. DIV/REM complete in 1 cycle with outAluResult = 0 and outRegWrite forced to 0. No stall is raised.

Test Plan:
- Reset mid-MUL: assert rst at BUSY cycle 10 -> all outputs 0, outStall 0, FSM IDLE; the next ADD completes normally.
- ADD with inALUSrc=1: A=5, imm=-3, inRegDst=1, inRd=7 -> next edge outAluResult=2, outDestReg=7, outRegWrite passes through, outStall=0 throughout.
- MUL: A=32'h0001_0003, B=32'h0000_0010 -> outStall high for 33 cycles. On the 34th edge, outAluResult=32'h0010_0030. Bubbles appear on the outputs in between.
- DIV with EX_DIV_EN: 100/7 -> quotient 14 after 34 edges; REM -> 2. Divide by 0 -> 32'hFFFFFFFF, and REM by 0 -> 100. Without EX_DIV_EN: DIV gives 0, outRegWrite=0, no stall.
- Branch: inBranch=1, A=B=9, inPc=8'hF8, imm=16 -> outBranchTaken=1, outBranchTarget=8'h08 (wrap). With A≠B -> outBranchTaken=0.
- Flush during BUSY at cycle 5: outStall falls that cycle, the next edge gives a bubble, and a following SUB 3-5 gives 32'hFFFFFFFE.
